// File: rtl/photonic_frame_tx.sv
// Framing serialiser for the photonic transmit path: preamble, LSB-first data
// beats and an optional per-lane parity beat, with back-to-back frame support.
module photonic_frame_tx #(
   parameter int unsigned      LANES     = 2,
   parameter int unsigned      BEATS     = 4,
   parameter int unsigned      PRE_BEATS = 1,
   parameter logic [LANES-1:0] PRE_WORD  = {LANES{1'b1}},
   parameter bit               PARITY    = 1'b1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   tx_en,
   input  logic [LANES*BEATS-1:0] in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [LANES-1:0]       tx_out,
   output logic                   tx_active
);

   localparam int unsigned W       = LANES * BEATS;
   localparam int unsigned CNT_MAX = (PRE_BEATS > BEATS) ? ((PRE_BEATS > 2) ? PRE_BEATS : 2)
                                                         : ((BEATS > 2) ? BEATS : 2);
   localparam int unsigned CW      = $clog2(CNT_MAX);
   localparam logic [CW-1:0] PRE_LAST  = CW'((PRE_BEATS == 0) ? 0 : PRE_BEATS - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(BEATS - 1);

   typedef enum logic [1:0] {IDLE, PRE, DATA, PAR} state_t;

   localparam state_t START = (PRE_BEATS == 0) ? DATA : PRE;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [W-1:0]     shift, shift_nxt;
   logic [LANES-1:0] par, par_nxt;
   logic             last_beat;
   logic             accept;

   assign last_beat = PARITY ? (state == PAR) : ((state == DATA) && (cnt == DATA_LAST));
   assign in_ready  = rst_n & tx_en & ((state == IDLE) | last_beat);
   assign accept    = in_valid & in_ready;
   assign tx_active = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         shift <= '0;
         par   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         shift <= shift_nxt;
         par   <= par_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      shift_nxt = shift;
      par_nxt   = par;
      tx_out    = '0;
      unique case (state)
         IDLE: ;
         PRE: begin
            tx_out = PRE_WORD;
            if (cnt == PRE_LAST) begin
               state_nxt = DATA;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         DATA: begin
            tx_out    = shift[LANES-1:0];
            shift_nxt = shift >> LANES;
            par_nxt   = par ^ shift[LANES-1:0];
            if (cnt == DATA_LAST) begin
               cnt_nxt   = '0;
               state_nxt = PARITY ? PAR : IDLE;
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         PAR: begin
            tx_out    = par;
            state_nxt = IDLE;
         end
         default: ;
      endcase
      // Accept only fires in IDLE or on the last beat, so it safely overrides the frame-end path.
      if (accept) begin
         state_nxt = START;
         cnt_nxt   = '0;
         shift_nxt = in_data;
         par_nxt   = '0;
      end
   end

endmodule

// File: tb/tb_photonic_frame_tx.sv
// Bench for photonic_frame_tx: a default instance and a PARITY=0 instance share
// stimulus; a beat-queue model is checked every cycle alongside literal frame vectors.
module tb_photonic_frame_tx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tx_en = 1'b1;
   logic [7:0] in_data = 8'hB4;
   logic       in_valid = 1'b1;

   logic       rdy0, act0, rdy1, act1;
   logic [1:0] tx0, tx1;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   photonic_frame_tx dut0 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy0), .tx_out(tx0), .tx_active(act0)
   );

   photonic_frame_tx #(.PARITY(1'b0)) dut1 (
      .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .in_data(in_data), .in_valid(in_valid),
      .in_ready(rdy1), .tx_out(tx1), .tx_active(act1)
   );

   task automatic chk(input string nm, input logic [11:0] act, input logic [11:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
      end
   endtask

   // Beat i of a frame: preamble, four LSB-first data beats, then XOR parity.
   function automatic logic [1:0] beat_of(input logic [7:0] d, input int i);
      if (i == 0) return 2'b11;
      if (i <= 4) return d[2*(i-1) +: 2];
      return d[1:0] ^ d[3:2] ^ d[5:4] ^ d[7:6];
   endfunction

   // Model: front of each queue is the beat on the lanes during the current cycle.
   logic [1:0] q0[$];
   logic [1:0] q1[$];
   bit         chk_en = 1'b0;
   bit         acc0, acc1;

   always @(posedge clk) begin
      if (!rst_n) begin
         q0.delete();
         q1.delete();
      end else begin
         acc0 = in_valid && tx_en && (q0.size() <= 1);
         acc1 = in_valid && tx_en && (q1.size() <= 1);
         if (q0.size() != 0) void'(q0.pop_front());
         if (q1.size() != 0) void'(q1.pop_front());
         if (acc0) for (int i = 0; i < 6; i++) q0.push_back(beat_of(in_data, i));
         if (acc1) for (int i = 0; i < 5; i++) q1.push_back(beat_of(in_data, i));
      end
      chk_en = 1'b1;
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m0_tx",  12'(tx0),  12'((q0.size() != 0) ? q0[0] : 2'b00));
         chk("m0_act", 12'(act0), 12'(q0.size() != 0));
         chk("m0_rdy", 12'(rdy0), 12'(rst_n && tx_en && (q0.size() <= 1)));
         chk("m1_tx",  12'(tx1),  12'((q1.size() != 0) ? q1[0] : 2'b00));
         chk("m1_act", 12'(act1), 12'(q1.size() != 0));
         chk("m1_rdy", 12'(rdy1), 12'(rst_n && tx_en && (q1.size() <= 1)));
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // exp0/exp1 hold beat i at bits [2i+1:2i].
   task automatic run_frame(input logic [7:0] d, input logic [11:0] exp0, input logic [9:0] exp1);
      in_data  = d;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      in_data  = 8'hFF;
      for (int i = 0; i < 6; i++) begin
         chk("lit0_tx", 12'(tx0), 12'(exp0[2*i +: 2]));
         chk("lit0_act", 12'(act0), 12'd1);
         if (i < 5) chk("lit1_tx", 12'(tx1), 12'(exp1[2*i +: 2]));
         else       chk("lit1_end", 12'({act1, tx1}), 12'd0);
         tick();
      end
      chk("lit0_end", 12'({act0, tx0}), 12'd0);
   endtask

   logic [23:0] b2b;

   initial begin
      // Reset held with valid and enable asserted.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("rst_out", 12'({rdy0, act0, tx0}), 12'd0);
      end
      rst_n    = 1'b1;
      in_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("idle_rdy", 12'(rdy0), 12'd1);
         chk("idle_tx", 12'(tx0), 12'd0);
      end

      run_frame(8'hB4, 12'h2D3, 10'h2D3);
      run_frame(8'h01, 12'h407, 10'h007);

      // Back-to-back B4 then 01 with valid held.
      b2b      = {12'h407, 12'h2D3};
      in_data  = 8'hB4;
      in_valid = 1'b1;
      tick();
      in_data = 8'h01;
      for (int i = 0; i < 12; i++) begin
         chk("b2b_tx", 12'(tx0), 12'(b2b[2*i +: 2]));
         chk("b2b_act", 12'(act0), 12'd1);
         if (i <= 10) chk("b2b_rdy", 12'(rdy0), 12'(i == 5 || i == 11));
         if (i == 6) in_valid = 1'b0;
         tick();
      end
      chk("b2b_end", 12'({act0, tx0}), 12'd0);

      // Enable gating, then enable dropped during DATA.
      tx_en    = 1'b0;
      in_data  = 8'hB4;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("gate_rdy", 12'(rdy0), 12'd0);
         chk("gate_tx", 12'({act0, tx0}), 12'd0);
      end
      tx_en = 1'b1;
      tick();
      for (int i = 0; i < 6; i++) begin
         chk("drop_tx", 12'(tx0), 12'(beat_of(8'hB4, i)));
         if (i == 1) tx_en = 1'b0;
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         chk("drop_idle", 12'({act0, tx0}), 12'd0);
         tick();
      end
      in_valid = 1'b0;
      tx_en    = 1'b1;
      tick();

      // Reset during the second data beat.
      in_data  = 8'hB4;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      chk("mid_beat", 12'(tx0), 12'(2'b01));
      rst_n = 1'b0;
      tick();
      chk("mid_rst", 12'({act0, tx0}), 12'd0);
      rst_n = 1'b1;
      tick();
      run_frame(8'h01, 12'h407, 10'h007);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/photonic_frame_tx.md
# photonic_frame_tx

Parametrised framing serialiser for the photonic transmitter path. It accepts a parallel word over a valid/ready handshake and drives it onto LANES modulator lanes (one bit per wavelength per cycle) as a frame:

- preamble beats,
- BEATS data beats, LSB lane-group first,
- an optional per-lane parity beat.

A modulator-enable input gates new frames. Lanes are driven to 0 whenever no frame is in flight. It sits between the core-side network interface and the optical modulator drivers, and generalises the earlier fixed-width gated transmitter to framed, multi-beat, back-to-back operation.

## Interface
- LANES, 2: optical lanes (tx_out width), ≥1
- BEATS, 4: data beats per word; word width W = LANES*BEATS, ≥1
- PRE_BEATS, 1: preamble beats per frame, ≥0 (0 = no preamble)
- PRE_WORD, all ones ({LANES{1'b1}}): LANES-bit pattern driven on every preamble beat
- PARITY, 1: 1 = append parity beat, 0 = none

- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- tx_en  in  1  modulator enable; gates acceptance of new words
- in_data  in  W  word to transmit
- in_valid  in  1  in_data valid
- in_ready  out  1  block can accept a word this cycle
- tx_out  out  LANES  modulator drive, one bit per lane
- tx_active  out  1  frame in flight (state ≠ IDLE)

## Operation
- FSM states: IDLE, PRE, DATA, PAR. Registers: state, beat counter ($clog2 of max(PRE_BEATS,BEATS,2) bits), W-bit shift register, LANES-bit parity accumulator.
- in_ready = rst_n & tx_en & (state==IDLE | last beat of frame).
  - The last beat of a frame is PAR when PARITY=1, else DATA with count==BEATS-1.
- Accept = in_valid & in_ready. On accept:
  - load the shift register with in_data;
  - clear the parity accumulator and the counter;
  - go to PRE, or to DATA if PRE_BEATS==0.
- IDLE: tx_out = 0. No accept keeps the block in IDLE.
- PRE: tx_out = PRE_WORD for PRE_BEATS cycles, then DATA.
- DATA: tx_out = shift_reg[LANES-1:0].
  - Each cycle: shift right by LANES and XOR tx_out into the parity accumulator.
  - After BEATS cycles go to PAR (PARITY=1) or end the frame.
- PAR: tx_out = parity accumulator, which is the XOR over all data beats per lane. One cycle, then end the frame.
- End of frame: if an accept occurs on the last beat, start the next frame (PRE or DATA) with no idle gap. Otherwise go to IDLE.
- tx_en deasserted mid-frame: the in-flight frame completes unchanged; only new acceptance is blocked.
- in_data is sampled only on accept; later changes have no effect.

## Timing
- Reset (rst_n low at an edge): state=IDLE, counter=0, shift register=0, parity=0. While reset holds, tx_out=0, tx_active=0, in_ready=0.
  - Reset mid-frame aborts the frame immediately; the next cycle drives tx_out=0.
- tx_out and tx_active are Moore outputs of registered state. No combinational path from in_data to tx_out.
- Latency: accept at edge k → first frame beat on tx_out during the cycle after edge k.
- Frame length L = PRE_BEATS + BEATS + PARITY cycles. Sustained throughput is one word per L cycles; defaults give L=6.
- in_ready depends combinationally on tx_en and on registered state only; it never depends on in_valid.

## Test plan
- Reset and idle: rst_n=0 for 3 cycles with in_valid=1, tx_en=1 → tx_out=00, in_ready=0, tx_active=0. After release, in_ready=1 and tx_out stays 00 until an accept.
- Single frame, defaults, in_data=8'hB4 → tx_out sequence 11,00,01,11,10,00 (preamble, 4 data beats, parity 00). tx_active high for exactly 6 cycles, then tx_out=00.
- Parity check, in_data=8'h01 → 11,01,00,00,00,01. With PARITY=0 → 11,01,00,00,00 and the frame ends after 5 cycles.
- Back-to-back: in_valid held with 8'hB4 then 8'h01 → 12 consecutive active beats with no gap. in_ready is high only on cycle 6 of the first frame.
- Enable gating: tx_en=0 with in_valid=1 → in_ready=0 and tx_out=00 indefinitely. Dropping tx_en during DATA → the current frame completes and no new frame starts.
- Reset mid-frame: rst_n=0 during the second data beat → tx_out=00 and tx_active=0 on the following cycle. After release, a new 8'h01 frame transmits cleanly.
